adder_pipe: RTL

Parametrised pipelined add/subtract unit, successor to the fixed 64-bit adder in the execution datapath. It splits a WIDTH-bit carry chain across STAGES register stages, adds a subtract mode and signed-overflow flag, and replaces the one-way valid/rdy pulse with a full two-sided handshake so that downstream backpressure stalls the pipeline without losing operands. It sits between operand issue and the result writeback mux in the integer datapath.

---
 rtl/adder_pkg.sv | 36 +++
 rtl/adder_slice.sv | 54 +++++
 rtl/adder_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined add/subtract unit:
//   LEN_DATA      default datapath width
//   map_operands  turns (b, cin, sub) into the adder's effective b and carry-in
//   cfg_ok        elaboration-time legality test for WIDTH/STAGES
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam int LEN_DATA = 64;

  // Widest operand the mapping helper handles; callers zero-extend into it.
  localparam int MAX_W = 1024;

  typedef logic [MAX_W-1:0] wide_t;

  typedef struct packed {
    wide_t b_eff;
    logic  c0;
  } opmap_t;

  // a - b - cin is computed as a + ~b + ~cin, so subtraction only needs
  // b and the carry-in inverted ahead of an ordinary adder.
  function automatic opmap_t map_operands(input wide_t b, input logic cin, input logic sub);
    opmap_t m;
    m.b_eff = b ^ {MAX_W{sub}};
    m.c0    = cin ^ sub;
    return m;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && (width <= MAX_W) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// One CHUNK-bit stage of the pipelined adder: adds its operand slices with
// the incoming carry and registers partial sum, carry out and valid bit.
// Every register holds while adv is low.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   adv           pipeline advance enable
//   i_vld         valid bit of the operand entering this stage
//   i_a, i_b, i_c operand slices and carry-in
//   o_vld         registered valid bit
//   o_s, o_c      registered partial sum slice and carry out
// ---------------------------------------------------------------------------
module adder_slice
  import adder_pkg::*;
#(
  parameter int CHUNK = LEN_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             i_vld,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_c,
  output logic             o_vld,
  output logic [CHUNK-1:0] o_s,
  output logic             o_c
);

  logic [CHUNK:0]   w_add;
  logic             r_vld;
  logic             r_c;
  logic [CHUNK-1:0] r_s;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_c};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_s   <= '0;
      r_c   <= 1'b0;
    end else if (adv) begin
      r_vld <= i_vld;
      r_s   <= w_add[CHUNK-1:0];
      r_c   <= w_add[CHUNK];
    end
  end

  assign o_vld = r_vld;
  assign o_s   = r_s;
  assign o_c   = r_c;

endmodule

// File: rtl/adder_pipe.sv
// ---------------------------------------------------------------------------
// adder_pipe
// Pipelined WIDTH-bit add/subtract unit. The carry chain is cut into STAGES
// slices of CHUNK = WIDTH/STAGES bits, one register stage per slice, with a
// two-sided handshake on both ends. The whole pipeline advances in lockstep
// (no bubble compaction); it stalls when the result is not taken or en is low.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   en             global enable (0 freezes every stage, forces ready low)
//   valid, ready   operand handshake
//   a, b, cin, sub operands; sub=1 computes a - b - cin
//   sum, cout, ovf result, raw carry out, signed overflow
//   rdy, ack       result handshake
// ---------------------------------------------------------------------------
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = LEN_DATA,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             rdy,
  input  logic             ack
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $fatal(1, "adder_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  opmap_t            w_map;
  logic [WIDTH-1:0]  w_beff;
  logic              w_c0;
  logic              w_adv;
  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_cy;
  logic [CHUNK-1:0]  w_s [STAGES];

  // Registers alongside stage k. r_a/r_b hold the not-yet-added operand
  // slices shifted down so the next stage always reads bits [CHUNK-1:0].
  // r_lo collects finished sum slices entering from the top and shifting
  // down, so after the last stage they sit in their final positions.
  logic [WIDTH-1:0]  r_a  [STAGES];
  logic [WIDTH-1:0]  r_b  [STAGES];
  logic [WIDTH-1:0]  r_lo [STAGES];
  logic [STAGES-1:0] r_am;
  logic [STAGES-1:0] r_bm;

  assign w_map  = map_operands(wide_t'(b), cin, sub);
  assign w_beff = WIDTH'(w_map.b_eff);
  assign w_c0   = w_map.c0;

  // rst is folded in so ready reads 0 while the unit is held in reset.
  assign w_adv = rst && en && (!rdy || ack);
  assign ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] w_in_a;
    logic [CHUNK-1:0] w_in_b;
    logic             w_in_c;
    logic             w_in_v;
    logic [WIDTH-1:0] w_nx_a;
    logic [WIDTH-1:0] w_nx_b;
    logic [WIDTH-1:0] w_nx_lo;
    logic             w_nx_am;
    logic             w_nx_bm;

    if (k == 0) begin : g_head
      assign w_in_a  = a[CHUNK-1:0];
      assign w_in_b  = w_beff[CHUNK-1:0];
      assign w_in_c  = w_c0;
      assign w_in_v  = valid;
      assign w_nx_a  = a >> CHUNK;
      assign w_nx_b  = w_beff >> CHUNK;
      assign w_nx_lo = '0;
      assign w_nx_am = a[WIDTH-1];
      assign w_nx_bm = w_beff[WIDTH-1];
    end else begin : g_body
      assign w_in_a  = r_a[k-1][CHUNK-1:0];
      assign w_in_b  = r_b[k-1][CHUNK-1:0];
      assign w_in_c  = w_cy[k-1];
      assign w_in_v  = w_vld[k-1];
      assign w_nx_a  = r_a[k-1] >> CHUNK;
      assign w_nx_b  = r_b[k-1] >> CHUNK;
      assign w_nx_lo = (r_lo[k-1] >> CHUNK) | (WIDTH'(w_s[k-1]) << (WIDTH - CHUNK));
      assign w_nx_am = r_am[k-1];
      assign w_nx_bm = r_bm[k-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .clk   (clk),
      .rst   (rst),
      .adv   (w_adv),
      .i_vld (w_in_v),
      .i_a   (w_in_a),
      .i_b   (w_in_b),
      .i_c   (w_in_c),
      .o_vld (w_vld[k]),
      .o_s   (w_s[k]),
      .o_c   (w_cy[k])
    );

    // Stage k boundary: operand/result delay triangle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_lo[k] <= '0;
        r_am[k] <= 1'b0;
        r_bm[k] <= 1'b0;
      end else if (w_adv) begin
        r_a[k]  <= w_nx_a;
        r_b[k]  <= w_nx_b;
        r_lo[k] <= w_nx_lo;
        r_am[k] <= w_nx_am;
        r_bm[k] <= w_nx_bm;
      end
    end
  end

  assign sum  = (r_lo[STAGES-1] >> CHUNK) | (WIDTH'(w_s[STAGES-1]) << (WIDTH - CHUNK));
  assign cout = w_cy[STAGES-1];
  assign rdy  = w_vld[STAGES-1];

  // Overflow: both addends share a sign and the result's sign differs.
  assign ovf = (r_am[STAGES-1] == r_bm[STAGES-1]) && (sum[WIDTH-1] != r_am[STAGES-1]);

endmodule
